seqdet_moore_param: RTL and testbench

Parametrised successor to the team's fixed "001" Moore sequence detector. Detects a compile-time pattern of PAT_W bits on a serial input, with selectable overlapping or non-overlapping detection, an input-valid qualifier and a saturating match counter. Sits on a serial bit stream (line decoder / framing front end), one bit per enabled clock. Output det is registered (Moore): it depends only on state, never combinationally on inp.

---
 rtl/seqdet_pkg.sv | 18 +
 rtl/seqdet_moore_param_if.sv | 15 +
 rtl/sat_counter.sv | 37 +++
 rtl/seqdet_moore_param.sv | 65 ++++++
 tb/tb_seqdet_moore_param.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/seqdet_pkg.sv
// Shared defaults and encodings for the parametrised serial pattern detector.
// Also holds the elaboration-time pattern-width helper.
package seqdet_pkg;

  localparam int          SEQ_PAT_W   = 3;
  localparam logic [31:0] SEQ_PATTERN = 32'b001;
  localparam int          SEQ_CNT_W   = 8;

  localparam int SEQ_OVERLAP    = 1;
  localparam int SEQ_NONOVERLAP = 0;

  // True when no bit of p lies above the low w bits.
  function automatic bit pat_fits(input logic [31:0] p, input int w);
    if (w >= 32) return 1'b1;
    return (p >> w) == 32'd0;
  endfunction

endpackage

// File: rtl/seqdet_moore_param_if.sv
// Serial-in / detection-out bundle for seqdet_moore_param.
// The stream source is the master; the detector is the slave.
interface seqdet_moore_param_if #(
  parameter int CNT_W = seqdet_pkg::SEQ_CNT_W
) ();
  logic             clr;
  logic             en;
  logic             inp;
  logic             det;
  logic [CNT_W-1:0] match_cnt;
  logic             cnt_sat;

  modport master (output clr, en, inp, input det, match_cnt, cnt_sat);
  modport slave  (input clr, en, inp, output det, match_cnt, cnt_sat);
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and a registered all-ones flag.
// Async active-low reset.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         sat
);

  localparam logic [W-1:0] MAX   = {W{1'b1}};
  localparam logic [W-1:0] PRE_M = MAX - 1'b1;

  logic [W-1:0] count_q;
  logic         sat_q;

  // sat_q tracks count_q == MAX so it never needs a wide compare on the output path.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      sat_q   <= 1'b0;
    end else if (clr) begin
      count_q <= '0;
      sat_q   <= 1'b0;
    end else if (inc && !sat_q) begin
      count_q <= count_q + 1'b1;
      sat_q   <= (count_q == PRE_M);
    end
  end

  assign count = count_q;
  assign sat   = sat_q;

endmodule

// File: rtl/seqdet_moore_param.sv
// Moore detector for a PAT_W-bit pattern on an en-qualified serial stream,
// with optional overlap and a saturating match counter.
module seqdet_moore_param
  import seqdet_pkg::*;
#(
  parameter int          PAT_W   = SEQ_PAT_W,
  parameter logic [31:0] PATTERN = SEQ_PATTERN,
  parameter int          OVERLAP = SEQ_OVERLAP,
  parameter int          CNT_W   = SEQ_CNT_W
) (
  input logic                 clk,
  input logic                 rst,
  seqdet_moore_param_if.slave bus
);

  if (PAT_W < 2 || PAT_W > 32) begin : g_bad_w
    $fatal(1, "seqdet_moore_param: PAT_W=%0d outside 2..32", PAT_W);
  end
  if (!pat_fits(PATTERN, PAT_W)) begin : g_bad_pat
    $fatal(1, "seqdet_moore_param: PATTERN wider than PAT_W=%0d", PAT_W);
  end

  localparam int               FW   = $clog2(PAT_W + 1);
  localparam logic [FW-1:0]    FULL = FW'(PAT_W);
  localparam logic [PAT_W-1:0] PAT  = PATTERN[PAT_W-1:0];

  logic [PAT_W-1:0] hist_q, cand;
  logic [FW-1:0]    fill_q, fill_n;
  logic             det_q, hit;

  assign cand   = {hist_q[PAT_W-2:0], bus.inp};
  assign fill_n = (fill_q == FULL) ? FULL : fill_q + 1'b1;
  // fill gates the compare so a zero pattern cannot fire on the reset history.
  assign hit    = bus.en && !bus.clr && (fill_n == FULL) && (cand == PAT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q <= '0;
      fill_q <= '0;
      det_q  <= 1'b0;
    end else if (bus.clr) begin
      hist_q <= '0;
      fill_q <= '0;
      det_q  <= 1'b0;
    end else if (bus.en) begin
      hist_q <= cand;
      det_q  <= hit;
      fill_q <= (hit && OVERLAP == SEQ_NONOVERLAP) ? '0 : fill_n;
    end else begin
      det_q  <= 1'b0;
    end
  end

  sat_counter #(.W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (bus.clr),
    .inc   (hit),
    .count (bus.match_cnt),
    .sat   (bus.cnt_sat)
  );

  assign bus.det = det_q;

endmodule

// File: tb/tb_seqdet_moore_param.sv
// Several detector configurations share one stimulus stream; each has its own
// queue-based reference model feeding a scoreboard checked at the falling edge.
module tb_seqdet_moore_param;

  localparam int          NC = 7;
  localparam int          PWS  [NC] = '{3, 4, 4, 2, 2, 3, 3};
  localparam logic [31:0] PATS [NC] = '{32'b001, 32'b1011, 32'b1011, 32'b11, 32'b11, 32'b001, 32'b000};
  localparam int          OVS  [NC] = '{1, 1, 0, 1, 0, 1, 0};
  localparam int          CWS  [NC] = '{8, 8, 8, 8, 8, 2, 8};

  typedef struct { bit d; longint c; bit s; } exp_t;

  logic clk = 1'b0;
  logic rst, clr, en, inp;
  int   tests = 0;
  int   fails = 0;

  logic [NC-1:0][31:0] cnt_mon;
  logic [NC-1:0]       sat_mon;

  always #5 clk = ~clk;

  task automatic check(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < NC; g++) begin : cfg
    localparam int          PW   = PWS[g];
    localparam logic [31:0] PT   = PATS[g];
    localparam int          OV   = OVS[g];
    localparam int          CW   = CWS[g];
    localparam longint      MAXC = (longint'(1) << CW) - 1;

    seqdet_moore_param_if #(.CNT_W(CW)) u_if ();
    assign u_if.clr = clr;
    assign u_if.en  = en;
    assign u_if.inp = inp;
    assign cnt_mon[g] = 32'(u_if.match_cnt);
    assign sat_mon[g] = u_if.cnt_sat;

    seqdet_moore_param #(.PAT_W(PW), .PATTERN(PT), .OVERLAP(OV), .CNT_W(CW)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if)
    );

    // Model: keep the accepted bits of the current match window, newest last.
    bit          bits[$];
    bit          det_m;
    longint      cnt_m;
    logic [31:0] v;
    exp_t        sb[$];
    exp_t        e;

    always @(negedge rst) begin
      bits.delete();
      det_m = 1'b0;
      cnt_m = 0;
      #1;
      check($sformatf("c%0d_rst_det", g), longint'(u_if.det), 0);
      check($sformatf("c%0d_rst_cnt", g), longint'(u_if.match_cnt), 0);
      check($sformatf("c%0d_rst_sat", g), longint'(u_if.cnt_sat), 0);
    end

    always @(posedge clk) begin
      if (!rst || clr) begin
        bits.delete();
        det_m = 1'b0;
        cnt_m = 0;
      end else if (en) begin
        bits.push_back(inp);
        if (bits.size() > PW) void'(bits.pop_front());
        v = '0;
        foreach (bits[i]) v = (v << 1) | 32'(bits[i]);
        det_m = (bits.size() == PW) && (v == PT);
        if (det_m) begin
          if (cnt_m < MAXC) cnt_m++;
          if (OV == 0) bits.delete();
        end
      end else begin
        det_m = 1'b0;
      end
      sb.push_back('{det_m, cnt_m, cnt_m == MAXC});
    end

    always @(negedge clk) begin
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check($sformatf("c%0d_det", g), longint'(u_if.det), longint'(e.d));
        check($sformatf("c%0d_cnt", g), longint'(u_if.match_cnt), e.c);
        check($sformatf("c%0d_sat", g), longint'(u_if.cnt_sat), longint'(e.s));
      end
    end
  end

  task automatic drv(input logic e_i, input logic b_i);
    @(negedge clk);
    clr = 1'b0; en = e_i; inp = b_i;
  endtask

  task automatic drv_clr();
    @(negedge clk);
    clr = 1'b1; en = 1'($urandom); inp = 1'($urandom);
  endtask

  task automatic send(input logic [31:0] bits_i, input int n);
    for (int i = n - 1; i >= 0; i--) drv(1'b1, bits_i[i]);
  endtask

  // Reset lands mid-cycle; hold=1 keeps it low across the next rising edge.
  task automatic pulse_rst(input bit hold);
    @(negedge clk);
    clr = 1'b0; en = 1'b0;
    #2 rst = 1'b0;
    if (hold) begin
      @(negedge clk);
      #2 rst = 1'b1;
    end else begin
      #2 rst = 1'b1;
    end
  endtask

  initial begin
    rst = 1'b0; clr = 1'b0; en = 1'b0; inp = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    check("reset_cnt0", longint'(cnt_mon[0]), 0);

    send(32'b0011001110, 10);
    drv(1'b0, 1'b0);
    check("dflt_stream_cnt", longint'(cnt_mon[0]), 2);
    check("cw2_stream_sat", longint'(sat_mon[5]), 0);

    drv_clr(); send(32'b1011011, 7); drv(1'b0, 1'b0);
    check("p1011_ovl_cnt", longint'(cnt_mon[1]), 2);
    check("p1011_novl_cnt", longint'(cnt_mon[2]), 1);

    drv_clr(); send(32'b1111, 4); drv(1'b0, 1'b0);
    check("p11_ovl_cnt", longint'(cnt_mon[3]), 3);
    check("p11_novl_cnt", longint'(cnt_mon[4]), 2);

    drv_clr(); drv(1'b1, 1'b0);
    repeat (3) drv(1'b0, 1'b1);
    drv(1'b1, 1'b0); drv(1'b1, 1'b1); drv(1'b0, 1'b0);
    check("gap_cnt", longint'(cnt_mon[0]), 1);

    drv_clr(); send(32'b00, 2); pulse_rst(1'b1); drv(1'b1, 1'b1); drv(1'b0, 1'b0);
    check("rst_partial_cnt", longint'(cnt_mon[0]), 0);
    send(32'b001, 3); drv(1'b0, 1'b0);
    check("rst_after_cnt", longint'(cnt_mon[0]), 1);

    drv_clr(); send(32'b00, 2); drv_clr(); drv(1'b1, 1'b1); drv(1'b0, 1'b0);
    check("clr_partial_cnt", longint'(cnt_mon[0]), 0);
    send(32'b001, 3); drv(1'b0, 1'b0);
    check("clr_after_cnt", longint'(cnt_mon[0]), 1);

    drv_clr(); send(32'b001001001001001, 15); drv(1'b0, 1'b0);
    check("cw2_sat_cnt", longint'(cnt_mon[5]), 3);
    check("cw2_sat_flag", longint'(sat_mon[5]), 1);
    check("cw8_five_cnt", longint'(cnt_mon[0]), 5);

    for (int i = 0; i < 2000; i++) begin
      int r;
      r = int'($urandom_range(0, 199));
      if (r == 0)     pulse_rst(1'($urandom_range(0, 1)));
      else if (r < 4) drv_clr();
      else            drv($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
    end

    repeat (3) drv(1'b0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
